// File: rtl/ps2_rx_scancode.sv
// PS/2 keyboard receiver: synchronised, deglitched sampling, 11-bit frame checking with
// stall timeout, E0/F0 prefix folding and a first-word-fall-through event FIFO.
module ps2_rx_scancode #(
    parameter int unsigned CLK_DIV    = 250,
    parameter int unsigned FILT_LEN   = 4,
    parameter int unsigned TIMEOUT    = 4000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic                                  PS2_CLK,
    input  logic                                  PS2_DATA,
    output logic                                  EV_VALID,
    input  logic                                  EV_READY,
    output logic [7:0]                            EV_CODE,
    output logic                                  EV_EXT,
    output logic                                  EV_BREAK,
    output logic                                  FRAME_ERR,
    output logic                                  OVERFLOW,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       FIFO_LEVEL
);

    localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned EW = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic [DW-1:0] div_cnt;
    logic          tick_c;
    logic          filt_lvl;
    logic [FW-1:0] run_cnt;
    logic          fall_c;
    logic [10:0]   shreg;

    logic [1:0]    state, state_nx;
    logic [3:0]    bitcnt, bitcnt_nx;
    logic [TW-1:0] idle_cnt, idle_nx;
    logic          ext_pend, ext_nx, brk_pend, brk_nx;
    logic          err_nx, push_c, frame_ok_c;
    logic [7:0]    rx_byte_c;

    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_q, level_nx;
    logic          ev_valid_q, frame_err_q, overflow_q;
    logic          pop_c, full_c, push_ok_c;

    // Two-flop synchronisers; idle bus level is high
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            dat_s1 <= PS2_DATA;
            dat_s2 <= dat_s1;
        end
    end

    assign tick_c = (div_cnt == DW'(CLK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST)         div_cnt <= '0;
        else if (tick_c) div_cnt <= '0;
        else             div_cnt <= div_cnt + DW'(1);
    end

    // Filtered clock flips only after FILT_LEN consecutive disagreeing ticks
    always_ff @(posedge CLK) begin
        if (RST) begin
            filt_lvl <= 1'b1;
            run_cnt  <= '0;
        end else if (tick_c) begin
            if (clk_s2 != filt_lvl) begin
                if (run_cnt == FW'(FILT_LEN - 1)) begin
                    filt_lvl <= clk_s2;
                    run_cnt  <= '0;
                end else begin
                    run_cnt <= run_cnt + FW'(1);
                end
            end else begin
                run_cnt <= '0;
            end
        end
    end

    assign fall_c = tick_c && filt_lvl && !clk_s2 && (run_cnt == FW'(FILT_LEN - 1));

    always_ff @(posedge CLK) begin
        if (RST)         shreg <= '0;
        else if (fall_c) shreg <= {dat_s2, shreg[10:1]};
    end

    assign rx_byte_c  = shreg[8:1];
    assign frame_ok_c = !shreg[0] && shreg[10] && (^shreg[9:1]);

    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Frame sequencing, timeout and prefix folding
    always_comb begin
        state_nx  = state;
        bitcnt_nx = bitcnt;
        idle_nx   = idle_cnt;
        ext_nx    = ext_pend;
        brk_nx    = brk_pend;
        err_nx    = 1'b0;
        push_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall_c) begin
                    state_nx  = ST_SHIFT;
                    bitcnt_nx = 4'd1;
                    idle_nx   = '0;
                end
            end
            ST_SHIFT: begin
                if (fall_c) begin
                    idle_nx   = '0;
                    bitcnt_nx = bitcnt + 4'd1;
                    if (bitcnt == 4'd10) state_nx = ST_CHECK;
                end else if (tick_c) begin
                    if (idle_cnt == TW'(TIMEOUT - 1)) begin
                        state_nx  = ST_IDLE;
                        bitcnt_nx = 4'd0;
                        idle_nx   = '0;
                        err_nx    = 1'b1;
                    end else begin
                        idle_nx = idle_cnt + TW'(1);
                    end
                end
            end
            ST_CHECK: begin
                state_nx  = ST_IDLE;
                bitcnt_nx = 4'd0;
                if (!frame_ok_c) begin
                    err_nx = 1'b1;
                    ext_nx = 1'b0;
                    brk_nx = 1'b0;
                end else if (rx_byte_c == 8'hE0) begin
                    ext_nx = 1'b1;
                end else if (rx_byte_c == 8'hF0) begin
                    brk_nx = 1'b1;
                end else begin
                    push_c = 1'b1;
                    ext_nx = 1'b0;
                    brk_nx = 1'b0;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            bitcnt      <= '0;
            idle_cnt    <= '0;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bitcnt      <= bitcnt_nx;
            idle_cnt    <= idle_nx;
            ext_pend    <= ext_nx;
            brk_pend    <= brk_nx;
            frame_err_q <= err_nx;
        end
    end

    // Event FIFO; a full FIFO still accepts a push when the head is popped that cycle
    assign pop_c     = ev_valid_q && EV_READY;
    assign full_c    = (level_q == LW'(FIFO_DEPTH));
    assign push_ok_c = push_c && (!full_c || pop_c);

    always_comb begin
        level_nx = level_q;
        case ({push_ok_c, pop_c})
            2'b10:   level_nx = level_q + LW'(1);
            2'b01:   level_nx = level_q - LW'(1);
            default: level_nx = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            ev_valid_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok_c) begin
                mem[wr_ptr] <= {ext_pend, brk_pend, rx_byte_c};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + AW'(1);
            level_q    <= level_nx;
            ev_valid_q <= (level_nx != '0);
            if (push_c && !push_ok_c) overflow_q <= 1'b1;
        end
    end

    assign EV_VALID   = ev_valid_q;
    assign EV_CODE    = mem[rd_ptr][7:0];
    assign EV_BREAK   = mem[rd_ptr][8];
    assign EV_EXT     = mem[rd_ptr][9];
    assign FRAME_ERR  = frame_err_q;
    assign OVERFLOW   = overflow_q;
    assign FIFO_LEVEL = level_q;

endmodule

// File: tb/tb_ps2_rx_scancode.sv
// Directed bench for ps2_rx_scancode: frames, prefixes, errors, timeout, glitches, FIFO, reset.
module tb_ps2_rx_scancode;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic       EV_READY = 1'b0;
    logic       EV_VALID, EV_EXT, EV_BREAK, FRAME_ERR, OVERFLOW;
    logic [7:0] EV_CODE;
    logic [2:0] FIFO_LEVEL;

    int checks = 0;
    int failures = 0;
    int err_cnt = 0;
    logic [9:0] evq [$];

    ps2_rx_scancode #(
        .CLK_DIV(4), .FILT_LEN(2), .TIMEOUT(50), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .RST(RST), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA),
        .EV_VALID(EV_VALID), .EV_READY(EV_READY), .EV_CODE(EV_CODE),
        .EV_EXT(EV_EXT), .EV_BREAK(EV_BREAK), .FRAME_ERR(FRAME_ERR),
        .OVERFLOW(OVERFLOW), .FIFO_LEVEL(FIFO_LEVEL)
    );

    always #5 CLK = ~CLK;

    // Record every accepted event and every FRAME_ERR cycle
    always @(negedge CLK) begin
        if (!RST) begin
            if (EV_VALID && EV_READY) evq.push_back({EV_EXT, EV_BREAK, EV_CODE});
            if (FRAME_ERR) err_cnt++;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [10:0] mkframe(input logic [7:0] b, input bit badpar);
        return {1'b1, (~^b) ^ badpar, b, 1'b0};
    endfunction

    // One PS/2 bit is 40 ticks (160 CLK); data set mid-high, low phase 80 CLK
    task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = f[i];
            if (glitch) begin
                wait_clk(20);
                PS2_CLK = 1'b0;
                wait_clk(4);
                PS2_CLK = 1'b1;
                wait_clk(16);
            end else begin
                wait_clk(40);
            end
            PS2_CLK = 1'b0;
            wait_clk(80);
            PS2_CLK = 1'b1;
            wait_clk(40);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit badpar, input bit glitch);
        send_bits(mkframe(b, badpar), 11, glitch);
        PS2_DATA = 1'b1;
        wait_clk(80);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        wait_clk(5);
        RST = 1'b0;
        wait_clk(2);
        checks++; if (EV_VALID !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", EV_VALID); end
        checks++; if (EV_CODE !== 8'h00) begin failures++; $display("FAIL reset_code got=%h want=00", EV_CODE); end
        checks++; if (EV_EXT !== 1'b0) begin failures++; $display("FAIL reset_ext got=%b want=0", EV_EXT); end
        checks++; if (EV_BREAK !== 1'b0) begin failures++; $display("FAIL reset_break got=%b want=0", EV_BREAK); end
        checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b want=0", FRAME_ERR); end
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b want=0", OVERFLOW); end
        checks++; if (FIFO_LEVEL !== 3'd0) begin failures++; $display("FAIL reset_level got=%0d want=0", FIFO_LEVEL); end
    endtask

    task automatic test_single();
        int q0 = evq.size();
        int e0 = err_cnt;
        EV_READY = 1'b1;
        send_byte(8'h1C, 1'b0, 1'b0);
        checks++; if (evq.size() !== q0 + 1) begin failures++; $display("FAIL single_count got=%0d want=%0d", evq.size() - q0, 1); end
        else begin
            checks++; if (evq[q0] !== {2'b00, 8'h1C}) begin failures++; $display("FAIL single_event got=%h want=%h", evq[q0], {2'b00, 8'h1C}); end
        end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL single_err got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_prefix();
        int q0 = evq.size();
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        checks++; if (evq.size() !== q0) begin failures++; $display("FAIL prefix_no_event got=%0d want=0", evq.size() - q0); end
        send_byte(8'h75, 1'b0, 1'b0);
        send_byte(8'h6B, 1'b0, 1'b0);
        checks++; if (evq.size() !== q0 + 2) begin failures++; $display("FAIL prefix_count got=%0d want=2", evq.size() - q0); end
        else begin
            checks++; if (evq[q0] !== {2'b11, 8'h75}) begin failures++; $display("FAIL prefix_ext_break got=%h want=%h", evq[q0], {2'b11, 8'h75}); end
            checks++; if (evq[q0+1] !== {2'b00, 8'h6B}) begin failures++; $display("FAIL prefix_cleared got=%h want=%h", evq[q0+1], {2'b00, 8'h6B}); end
        end
    endtask

    task automatic test_bad_parity();
        int q0 = evq.size();
        int e0 = err_cnt;
        send_byte(8'h1C, 1'b1, 1'b0);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL parity_err got=%0d want=1", err_cnt - e0); end
        checks++; if (evq.size() !== q0) begin failures++; $display("FAIL parity_no_event got=%0d want=0", evq.size() - q0); end
        e0 = err_cnt;
        send_byte(8'hF0, 1'b0, 1'b0);
        send_byte(8'h3A, 1'b1, 1'b0);
        send_byte(8'h1C, 1'b0, 1'b0);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL badclr_err got=%0d want=1", err_cnt - e0); end
        checks++; if (evq.size() !== q0 + 1) begin failures++; $display("FAIL badclr_count got=%0d want=1", evq.size() - q0); end
        else begin
            checks++; if (evq[q0] !== {2'b00, 8'h1C}) begin failures++; $display("FAIL badclr_event got=%h want=%h", evq[q0], {2'b00, 8'h1C}); end
        end
    endtask

    task automatic test_timeout();
        int q0 = evq.size();
        int e0 = err_cnt;
        send_bits(mkframe(8'h16, 1'b0), 5, 1'b0);
        PS2_DATA = 1'b1;
        wait_clk(240);
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err got=%0d want=1", err_cnt - e0); end
        checks++; if (FIFO_LEVEL !== 3'd0) begin failures++; $display("FAIL timeout_level got=%0d want=0", FIFO_LEVEL); end
        send_byte(8'h16, 1'b0, 1'b0);
        checks++; if (evq.size() !== q0 + 1) begin failures++; $display("FAIL timeout_recover_count got=%0d want=1", evq.size() - q0); end
        else begin
            checks++; if (evq[q0] !== {2'b00, 8'h16}) begin failures++; $display("FAIL timeout_recover got=%h want=%h", evq[q0], {2'b00, 8'h16}); end
        end
        checks++; if (err_cnt - e0 !== 1) begin failures++; $display("FAIL timeout_err_total got=%0d want=1", err_cnt - e0); end
    endtask

    task automatic test_glitch();
        int q0 = evq.size();
        int e0 = err_cnt;
        send_byte(8'h16, 1'b0, 1'b1);
        checks++; if (evq.size() !== q0 + 1) begin failures++; $display("FAIL glitch_count got=%0d want=1", evq.size() - q0); end
        else begin
            checks++; if (evq[q0] !== {2'b00, 8'h16}) begin failures++; $display("FAIL glitch_event got=%h want=%h", evq[q0], {2'b00, 8'h16}); end
        end
        checks++; if (err_cnt - e0 !== 0) begin failures++; $display("FAIL glitch_err got=%0d want=0", err_cnt - e0); end
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};
        int q0;
        EV_READY = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(codes[i], 1'b0, 1'b0);
        checks++; if (FIFO_LEVEL !== 3'd4) begin failures++; $display("FAIL ovf_level got=%0d want=4", FIFO_LEVEL); end
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b want=1", OVERFLOW); end
        checks++; if (EV_VALID !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b want=1", EV_VALID); end
        checks++; if (EV_CODE !== 8'h15) begin failures++; $display("FAIL ovf_head_hold got=%h want=15", EV_CODE); end
        q0 = evq.size();
        EV_READY = 1'b1;
        wait_clk(4);
        checks++; if (FIFO_LEVEL !== 3'd0) begin failures++; $display("FAIL drain_level got=%0d want=0", FIFO_LEVEL); end
        checks++; if (evq.size() !== q0 + 4) begin failures++; $display("FAIL drain_count got=%0d want=4", evq.size() - q0); end
        else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (evq[q0+i] !== {2'b00, codes[i]}) begin
                    failures++; $display("FAIL drain_order idx=%0d got=%h want=%h", i, evq[q0+i], {2'b00, codes[i]});
                end
            end
        end
        checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", OVERFLOW); end
    endtask

    task automatic test_reset_mid();
        int q0;
        EV_READY = 1'b0;
        send_byte(8'h2A, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        checks++; if (FIFO_LEVEL !== 3'd1) begin failures++; $display("FAIL rstmid_pre_level got=%0d want=1", FIFO_LEVEL); end
        send_bits(mkframe(8'h33, 1'b0), 5, 1'b0);
        RST = 1'b1;
        PS2_CLK = 1'b1;
        PS2_DATA = 1'b1;
        wait_clk(3);
        checks++; if (EV_VALID !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b want=0", EV_VALID); end
        checks++; if (EV_CODE !== 8'h00) begin failures++; $display("FAIL rstmid_code got=%h want=00", EV_CODE); end
        checks++; if (EV_EXT !== 1'b0) begin failures++; $display("FAIL rstmid_ext got=%b want=0", EV_EXT); end
        checks++; if (EV_BREAK !== 1'b0) begin failures++; $display("FAIL rstmid_break got=%b want=0", EV_BREAK); end
        checks++; if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL rstmid_frame_err got=%b want=0", FRAME_ERR); end
        checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL rstmid_overflow got=%b want=0", OVERFLOW); end
        checks++; if (FIFO_LEVEL !== 3'd0) begin failures++; $display("FAIL rstmid_level got=%0d want=0", FIFO_LEVEL); end
        RST = 1'b0;
        wait_clk(5);
        q0 = evq.size();
        EV_READY = 1'b1;
        send_byte(8'h4D, 1'b0, 1'b0);
        checks++; if (evq.size() !== q0 + 1) begin failures++; $display("FAIL rstmid_count got=%0d want=1", evq.size() - q0); end
        else begin
            checks++; if (evq[q0] !== {2'b00, 8'h4D}) begin failures++; $display("FAIL rstmid_event got=%h want=%h", evq[q0], {2'b00, 8'h4D}); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_prefix();
        test_bad_parity();
        test_timeout();
        test_glitch();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
